// File: rtl/sn_onewire_reader.sv
// rtl/sn_onewire_reader.sv - 1-wire serial-number ROM reader: reset/presence, Read ROM, 64-bit read, CRC8 check
module sn_onewire_reader #(
  parameter int T_RSTL = 19200,
  parameter int T_PDS  = 2800,
  parameter int T_RSTH = 16400,
  parameter int T_SLOT = 2800,
  parameter int T_W0L  = 2400,
  parameter int T_W1L  = 240,
  parameter int T_RDS  = 600,
  parameter int CNTW   = 15
) (
  input  logic        clk,
  input  logic        hard_rst,
  input  logic        start,
  input  logic        SNin,
  output logic        SNout,
  output logic        busy,
  output logic        done,
  output logic        no_presence,
  output logic        crc_ok,
  output logic [7:0]  family,
  output logic [47:0] serial
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RST_LOW   = 3'd1;
  localparam logic [2:0] PRES_WAIT = 3'd2;
  localparam logic [2:0] PRES_REC  = 3'd3;
  localparam logic [2:0] CMD       = 3'd4;
  localparam logic [2:0] READ      = 3'd5;
  localparam logic [2:0] FIN       = 3'd6;

  localparam logic [7:0]      READ_ROM = 8'h33;
  localparam logic [CNTW-1:0] RSTL_LD  = CNTW'(T_RSTL - 1);
  localparam logic [CNTW-1:0] PDS_LD   = CNTW'(T_PDS - 1);
  localparam logic [CNTW-1:0] RSTH_LD  = CNTW'(T_RSTH - 1);
  localparam logic [CNTW-1:0] SLOT_LD  = CNTW'(T_SLOT - 1);
  localparam logic [CNTW-1:0] W0L_LEN  = CNTW'(T_W0L);
  localparam logic [CNTW-1:0] W1L_LEN  = CNTW'(T_W1L);
  localparam logic [CNTW-1:0] RDS_AT   = CNTW'(T_RDS - 1);

  logic [2:0]      state;
  logic [CNTW-1:0] timer;
  logic [CNTW-1:0] slot_cyc;
  logic [5:0]      bit_idx;
  logic [63:0]     sr;
  logic [7:0]      crc;
  logic [7:0]      crc_next;
  logic            sn_m;
  logic            sn_s;
  logic            drive_low;
  logic            phase_end;
  logic            crc_fb;

  always_ff @(posedge clk or posedge hard_rst) begin
    if (hard_rst) begin
      sn_m <= 1'b1;
      sn_s <= 1'b1;
    end else begin
      sn_m <= SNin;
      sn_s <= sn_m;
    end
  end

  assign phase_end = (timer == '0);
  assign slot_cyc  = SLOT_LD - timer;
  assign crc_fb    = crc[0] ^ sn_s;
  assign crc_next  = {1'b0, crc[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);

  always_comb begin
    drive_low = 1'b0;
    case (state)
      RST_LOW: drive_low = 1'b1;
      CMD:     drive_low = slot_cyc < (READ_ROM[bit_idx[2:0]] ? W1L_LEN : W0L_LEN);
      READ:    drive_low = slot_cyc < W1L_LEN;
      default: drive_low = 1'b0;
    endcase
  end

  // SNout is registered so the pin never glitches; every low phase shifts by one cycle, widths are exact.
  always_ff @(posedge clk or posedge hard_rst) begin
    if (hard_rst) begin
      state       <= IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      sr          <= '0;
      crc         <= '0;
      SNout       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      no_presence <= 1'b0;
      crc_ok      <= 1'b0;
      family      <= '0;
      serial      <= '0;
    end else begin
      SNout <= ~drive_low;
      done  <= 1'b0;
      if (state != IDLE && state != FIN) timer <= timer - CNTW'(1);
      case (state)
        IDLE: begin
          if (start) begin
            state <= RST_LOW;
            timer <= RSTL_LD;
            busy  <= 1'b1;
          end
        end
        RST_LOW: begin
          if (phase_end) begin
            state <= PRES_WAIT;
            timer <= PDS_LD;
          end
        end
        PRES_WAIT: begin
          if (phase_end) begin
            if (sn_s) begin
              no_presence <= 1'b1;
              crc_ok      <= 1'b0;
              state       <= FIN;
              done        <= 1'b1;
            end else begin
              no_presence <= 1'b0;
              state       <= PRES_REC;
              timer       <= RSTH_LD;
            end
          end
        end
        PRES_REC: begin
          if (phase_end) begin
            state   <= CMD;
            timer   <= SLOT_LD;
            bit_idx <= '0;
            sr      <= '0;
            crc     <= '0;
          end
        end
        CMD: begin
          if (phase_end) begin
            timer <= SLOT_LD;
            if (bit_idx == 6'd7) begin
              state   <= READ;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 6'd1;
            end
          end
        end
        READ: begin
          if (slot_cyc == RDS_AT) begin
            sr  <= {sn_s, sr[63:1]};
            crc <= crc_next;
          end
          // Results are latched on entry to FIN so they are already valid while done is high.
          if (phase_end) begin
            timer <= SLOT_LD;
            if (bit_idx == 6'd63) begin
              state  <= FIN;
              done   <= 1'b1;
              family <= sr[7:0];
              serial <= sr[55:8];
              crc_ok <= (crc == 8'h00);
            end else begin
              bit_idx <= bit_idx + 6'd1;
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sn_onewire_reader.sv
// tb/tb_sn_onewire_reader.sv - scoreboard bench for sn_onewire_reader with a behavioural 1-wire slave
module tb_sn_onewire_reader;
  localparam int T_RSTL = 48;
  localparam int T_PDS  = 10;
  localparam int T_RSTH = 20;
  localparam int T_SLOT = 20;
  localparam int T_W0L  = 14;
  localparam int T_W1L  = 3;
  localparam int T_RDS  = 10;
  localparam int CNTW   = 8;
  localparam int LAT_FULL = T_RSTL + T_PDS + T_RSTH + 72 * T_SLOT;
  localparam int LAT_NOP  = T_RSTL + T_PDS;

  logic        clk = 1'b0;
  logic        hard_rst = 1'b1;
  logic        start = 1'b0;
  logic        SNout;
  logic        busy;
  logic        done;
  logic        no_presence;
  logic        crc_ok;
  logic [7:0]  family;
  logic [47:0] serial;
  logic        slave_drv = 1'b1;
  logic        slave_en = 1'b1;
  logic [63:0] rom_bits = '0;
  logic [7:0]  cmd_byte = 8'h33;
  wire         line = SNout & slave_drv;
  wire         SNin = line;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          t0;
    int          lat;
    logic [7:0]  fam;
    logic [47:0] ser;
    logic        crc;
    logic        nop;
  } exp_t;
  exp_t exp_q[$];
  logic busy_lost = 1'b0;

  sn_onewire_reader #(
    .T_RSTL(T_RSTL), .T_PDS(T_PDS), .T_RSTH(T_RSTH), .T_SLOT(T_SLOT),
    .T_W0L(T_W0L), .T_W1L(T_W1L), .T_RDS(T_RDS), .CNTW(CNTW)
  ) dut (
    .clk(clk), .hard_rst(hard_rst), .start(start), .SNin(SNin), .SNout(SNout),
    .busy(busy), .done(done), .no_presence(no_presence), .crc_ok(crc_ok),
    .family(family), .serial(serial)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] make_rom(input logic [7:0] f, input logic [47:0] s, input logic corrupt);
    logic [55:0] d;
    logic [7:0]  c;
    d = {s, f};
    c = 8'h00;
    for (int i = 0; i < 56; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 8'h8C;
      else c = c >> 1;
    end
    return {(corrupt ? 8'h00 : c), d};
  endfunction

  // Slave: presence after a long low, then holds the line low through the sample point for read-0 slots.
  int   lowrun = 0;
  int   slot_n = 100;
  int   hold = 0;
  int   pres_cnt = 0;
  int   last_fall = 0;
  logic sn_prev = 1'b1;
  always @(negedge clk) begin
    if (hold > 0) hold = hold - 1;
    if (pres_cnt > 0) pres_cnt = (pres_cnt >= 25) ? 0 : pres_cnt + 1;
    if (sn_prev === 1'b1 && SNout === 1'b0) begin
      if (slot_n >= 1 && slot_n <= 8) chk($sformatf("slot_period_%0d", slot_n), 64'(cyc - last_fall), 64'(T_SLOT));
      if (slot_n >= 8 && slot_n < 72 && rom_bits[slot_n-8] == 1'b0) hold = 12;
      last_fall = cyc;
      slot_n = slot_n + 1;
    end
    if (SNout === 1'b0) begin
      lowrun = lowrun + 1;
    end else begin
      if (sn_prev === 1'b0) begin
        if (lowrun > T_W0L) begin
          chk("reset_low_width", 64'(lowrun), 64'(T_RSTL));
          slot_n = slave_en ? 0 : 100;
          pres_cnt = slave_en ? 1 : 0;
        end else if (slot_n >= 1 && slot_n <= 8) begin
          chk($sformatf("cmd_low_width_%0d", slot_n - 1), 64'(lowrun),
              64'(cmd_byte[slot_n-1] ? T_W1L : T_W0L));
        end
      end
      lowrun = 0;
    end
    sn_prev = SNout;
    slave_drv = !(hold > 0 || (pres_cnt >= 3 && pres_cnt <= 22));
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && busy !== 1'b1) busy_lost = 1'b1;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("latency", 64'(cyc - e.t0), 64'(e.lat));
        chk("family", 64'(family), 64'(e.fam));
        chk("serial", 64'(serial), 64'(e.ser));
        chk("crc_ok", 64'(crc_ok), 64'(e.crc));
        chk("no_presence", 64'(no_presence), 64'(e.nop));
        chk("busy_at_done", 64'(busy), 64'(1));
        chk("busy_held", 64'(busy_lost), 64'(0));
        busy_lost = 1'b0;
      end
    end
  end

  task automatic run_start(input int lat, input logic [7:0] f, input logic [47:0] s, input logic c, input logic np);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e.t0 = cyc; e.lat = lat; e.fam = f; e.ser = s; e.crc = c; e.nop = np;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(done), 64'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  localparam logic [47:0] SER_A = 48'h0000_1A2B_3C4D;

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_SNout", 64'(SNout), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_no_presence", 64'(no_presence), 64'(0));
    chk("rst_crc_ok", 64'(crc_ok), 64'(0));
    chk("rst_family", 64'(family), 64'(0));
    chk("rst_serial", 64'(serial), 64'(0));
    hard_rst = 1'b0;
    idle(3);

    // Good ROM, with stray start pulses mid-run that must be ignored.
    rom_bits = make_rom(8'h01, SER_A, 1'b0);
    run_start(LAT_FULL, 8'h01, SER_A, 1'b1, 1'b0);
    idle(100);
    start = 1'b1; @(negedge clk); start = 1'b0;
    idle(900);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done(LAT_FULL + 50);
    idle(30);

    rom_bits = make_rom(8'h01, SER_A, 1'b1);
    run_start(LAT_FULL, 8'h01, SER_A, 1'b0, 1'b0);
    wait_done(LAT_FULL + 50);
    idle(5);

    slave_en = 1'b0;
    run_start(LAT_NOP, 8'h01, SER_A, 1'b0, 1'b1);
    wait_done(LAT_NOP + 50);
    slave_en = 1'b1;
    idle(5);

    rom_bits = make_rom(8'h01, SER_A, 1'b0);
    run_start(LAT_FULL, 8'h01, SER_A, 1'b1, 1'b0);
    wait_done(LAT_FULL + 50);

    // Back-to-back: all-zero ROM started on the cycle after done; previous results must hold meanwhile.
    rom_bits = make_rom(8'h00, 48'h0, 1'b0);
    run_start(LAT_FULL, 8'h00, 48'h0, 1'b1, 1'b0);
    idle(300);
    chk("hold_family", 64'(family), 64'h01);
    chk("hold_serial", 64'(serial), 64'(SER_A));
    chk("hold_crc_ok", 64'(crc_ok), 64'(1));
    wait_done(LAT_FULL + 50);
    idle(5);

    // Abort with hard_rst while SNout is low in a read slot.
    rom_bits = make_rom(8'h01, SER_A, 1'b0);
    run_start(LAT_FULL, 8'h01, SER_A, 1'b1, 1'b0);
    idle(500);
    n = 0;
    while (SNout !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("abort_point_low", 64'(SNout), 64'(0));
    void'(exp_q.pop_back());
    #2 hard_rst = 1'b1;
    #1;
    chk("abort_SNout", 64'(SNout), 64'(1));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_family", 64'(family), 64'(0));
    chk("abort_serial", 64'(serial), 64'(0));
    chk("abort_crc_ok", 64'(crc_ok), 64'(0));
    chk("abort_no_presence", 64'(no_presence), 64'(0));
    @(negedge clk);
    hard_rst = 1'b0;
    idle(LAT_FULL + 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
